// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// State encoding, reset instruction and PC step size.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        FULL = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    function automatic logic misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request bus and decode handshake of the fetch stage.
// The fetch unit is the master; memory and decode sit on the slave side.
interface fetch_unit_if;

    logic        out_imem_req;
    logic [31:0] out_imem_addr;
    logic        in_imem_ready;
    logic [31:0] in_imem_rdata;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        in_ready;

    modport master (
        output out_imem_req, out_imem_addr,
        output out_valid, out_pc, out_instr,
        input  in_imem_ready, in_imem_rdata, in_ready
    );

    modport slave (
        input  out_imem_req, out_imem_addr,
        input  out_valid, out_pc, out_instr,
        output in_imem_ready, in_imem_rdata, in_ready
    );

endinterface

// File: rtl/fetch_unit_pc_incr.sv
// PC + 4 incrementer as a half-adder ripple chain from gate primitives.
// Bits below the step bit pass through unchanged.
module pc_incr
    import fetch_pkg::*;
(
    input  logic [31:0] pc,
    output logic [31:0] pc_next
);

    localparam int SB = $clog2(PC_STEP);

    logic [31:SB] carry;

    assign pc_next[SB-1:0] = pc[SB-1:0];
    assign carry[SB] = 1'b1;

    genvar i;
    for (i = SB; i < 32; i++) begin : g_sum
        xor u_x (pc_next[i], pc[i], carry[i]);
    end
    for (i = SB; i < 31; i++) begin : g_carry
        and u_a (carry[i+1], pc[i], carry[i]);
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem request, one-entry buffer.
// Optional FETCH_MISALIGN_TRAP_EN rejects misaligned redirects with a pulse.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         in_clk,
    input  logic         in_rst_n,
    input  logic         in_stall,
    input  logic         in_redirect_valid,
    input  logic [31:0]  in_redirect_pc,
    fetch_unit_if.master bus,
    output logic         out_misalign
);

    fetch_state_e state, state_n;

    logic [31:0] pc, pc_n, pc_inc, tgt;
    logic        cap, bad;

    pc_incr u_pc_incr (
        .pc      (pc),
        .pc_next (pc_inc)
    );

    assign tgt = in_redirect_pc & ~(PC_STEP - 32'd1);

`ifdef FETCH_MISALIGN_TRAP_EN
    assign bad = misaligned(in_redirect_pc);

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) out_misalign <= 1'b0;
        else           out_misalign <= in_redirect_valid && bad;
    end
`else
    assign bad = 1'b0;
    assign out_misalign = 1'b0;
`endif

    assign bus.out_imem_req  = (state == REQ) && !in_stall;
    assign bus.out_imem_addr = pc;
    assign bus.out_valid     = (state == FULL);

    always_comb begin
        state_n = state;
        pc_n    = pc;
        cap     = 1'b0;
        if (in_redirect_valid) begin
            state_n = REQ;
            if (!bad) pc_n = tgt;
        end else begin
            unique case (state)
                IDLE: state_n = REQ;
                REQ: begin
                    if (bus.out_imem_req && bus.in_imem_ready)
                        state_n = WAIT;
                end
                WAIT: begin
                    cap     = 1'b1;
                    state_n = FULL;
                end
                FULL: begin
                    if (bus.in_ready) begin
                        pc_n    = pc_inc;
                        state_n = REQ;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            bus.out_pc    <= 32'h0;
            bus.out_instr <= NOP_INSTR;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            if (cap) begin
                bus.out_pc    <= pc;
                bus.out_instr <= bus.in_imem_rdata;
            end
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 32-bit RISC-V core, sitting between the instruction memory and decode. Holds the program counter, issues one word request at a time to instruction memory, and buffers the returned instruction with its PC. Hands each instruction to decode over a valid/ready handshake. Accepts branch/jump redirects from execute.

## Interface
- `RESET_PC`, default 32'h0000_0000, PC loaded on reset.
- `in_clk` input 1: single clock, rising edge.
- `in_rst_n` input 1: asynchronous, active-low reset.
- `in_stall` input 1: when high, no new memory request is issued.
- `in_redirect_valid` input 1: redirect PC this cycle.
- `in_redirect_pc` input 32: redirect target.
- `in_imem_ready` input 1: memory accepts the request this cycle.
- `in_imem_rdata` input 32: instruction word, valid the cycle after acceptance.
- `out_imem_req` output 1: request valid.
- `out_imem_addr` output 32: word address requested (equals current PC).
- `out_valid` output 1: buffered instruction available to decode.
- `out_pc` output 32: PC of buffered instruction.
- `out_instr` output 32: buffered instruction.
- `in_ready` input 1: decode accepts the instruction.
- `out_misalign` output 1: misaligned redirect flag (see Configuration).

## Operation
- States: IDLE, REQ, WAIT, FULL.
- IDLE is entered only from reset. It moves to REQ unconditionally on the first edge after reset release.
- REQ:
  - `out_imem_req = !in_stall`.
  - On `out_imem_req & in_imem_ready`, go to WAIT.
- WAIT:
  - Capture `in_imem_rdata` into `out_instr` and the PC into `out_pc`.
  - Go to FULL.
- FULL:
  - `out_valid = 1`.
  - On `in_ready`, PC <= PC + 4 and go to REQ.
- PC arithmetic is 32-bit unsigned. 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
- Redirect has priority over everything except reset. In any state it loads PC <= target and goes to REQ.
  - Redirect in WAIT: the in-flight response is discarded.
  - Redirect in FULL: the buffered instruction is dropped, with `out_valid` low from the next cycle.
  - Redirect coincident with an `in_ready` handshake: the handshake completes (decode takes the instruction) and PC takes the redirect target, not PC + 4.
- `in_stall` affects only REQ. It holds REQ with no request. WAIT and FULL ignore it.
- Reset mid-operation aborts any outstanding request. A memory response arriving after reset is ignored because the unit is in IDLE/REQ.

## Timing
- Reset values:
  - state IDLE
  - PC = `RESET_PC`
  - `out_imem_req` 0
  - `out_imem_addr` = `RESET_PC`
  - `out_valid` 0
  - `out_pc` 0
  - `out_instr` 32'h0000_0013 (NOP)
  - `out_misalign` 0
- The first request is asserted in the cycle after the first post-reset edge.
- Latency with memory and decode always ready:
  - request accepted at edge N
  - data captured at edge N+1
  - `out_valid` high after N+1
  - handshake at edge N+2
  - next request in the cycle after
- Peak throughput is one instruction per 3 cycles.
- Outputs are registered or decoded from state only. The only combinational path is `in_stall` to `out_imem_req`.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - A redirect with `in_redirect_pc[1:0] != 2'b00` does not change the PC.
  - It pulses `out_misalign` high for exactly one cycle.
  - The unit goes to REQ and refetches from the old PC.
- Not defined:
  - `in_redirect_pc[1:0]` is forced to 00 on load.
  - `out_misalign` is tied 0.

## Structure
- Shared package `fetch_pkg` holds:
  - state encoding (IDLE=2'd0, REQ=2'd1, WAIT=2'd2, FULL=2'd3)
  - `NOP_INSTR` = 32'h0000_0013
  - `PC_STEP` = 32'd4
- One sub-module, `pc_incr`: 32-bit +4 incrementer built from the gate library, used for the PC + 4 path.

## Test plan
- Reset release with `RESET_PC` = 32'h0000_1000:
  - `out_imem_req` 1 with addr 32'h0000_1000 one cycle after release.
  - With memory returning 32'h0050_0093, `out_valid` shows that instruction with `out_pc` 32'h0000_1000.
- Memory and decode always ready, 4 instructions:
  - Addresses 0x1000, 0x1004, 0x1008, 0x100C.
  - Each handshake is 3 cycles apart.
- `in_ready` low for 5 cycles in FULL:
  - `out_valid`, `out_pc` and `out_instr` stay stable.
  - No memory request is issued.
- Redirect to 32'h0000_2000 during WAIT:
  - The returned word never appears on `out_valid`.
  - The next request addr is 32'h0000_2000.
- PC at 32'hFFFF_FFFC with handshake: the next request addr is 32'h0000_0000.
- Redirect to 32'h0000_2002:
  - With the macro: `out_misalign` pulses 1 cycle and the PC is unchanged.
  - Without: the next addr is 32'h0000_2000.
